// File: rtl/seu_err_mgr.sv
// Central error manager for a bank of SEU-detecting registers: sticky pending
// flags, saturating per-source counters, threshold irq and round-robin reporting.
module seu_err_mgr #(
  parameter int N_SRC     = 4,
  parameter int CNT_WIDTH = 8,
  parameter int THRESHOLD = 16,
  localparam int SW       = $clog2(N_SRC)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_SRC-1:0]     error_i,
  input  logic                 clear_i,
  output logic                 evt_valid_o,
  input  logic                 evt_ready_i,
  output logic [SW-1:0]        evt_src_o,
  output logic [CNT_WIDTH-1:0] evt_cnt_o,
  output logic [N_SRC-1:0]     pending_o,
  output logic                 irq_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_THR  = CNT_WIDTH'(THRESHOLD);
  localparam logic [SW-1:0]        RR_INIT  = SW'(N_SRC - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_REPORT = 1'b1
  } state_t;

  state_t                 state_r;
  logic [CNT_WIDTH-1:0]   cnt_r     [N_SRC];
  logic [CNT_WIDTH-1:0]   cnt_nxt_s [N_SRC];
  logic [N_SRC-1:0]       pending_r;
  logic [N_SRC-1:0]       hs_mask_s;
  logic                   irq_r;
  logic                   thr_hit_s;
  logic                   hs_s;
  logic [SW-1:0]          rr_ptr_r;
  logic [SW-1:0]          sel_idx_s;
  logic                   sel_found_s;
  int                     dist_s;
  int                     best_dist_s;
  logic                   evt_valid_r;
  logic [SW-1:0]          evt_src_r;
  logic [CNT_WIDTH-1:0]   evt_cnt_r;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic                 en);
    if (en && (v != CNT_MAX)) begin
      sat_inc = v + CNT_ONE;
    end else begin
      sat_inc = v;
    end
  endfunction

  assign hs_s = (state_r == ST_REPORT) && evt_valid_r && evt_ready_i;

  // Next counter values, threshold detect and the handshake clear mask.
  always_comb begin
    thr_hit_s = 1'b0;
    hs_mask_s = {N_SRC{1'b0}};
    for (int k = 0; k < N_SRC; k++) begin
      cnt_nxt_s[k] = sat_inc(cnt_r[k], error_i[k]);
      thr_hit_s    = thr_hit_s | (cnt_r[k] >= CNT_THR);
      hs_mask_s[k] = hs_s & (evt_src_r == SW'(k));
    end
  end

  // Round-robin pick: pending source at the smallest distance past rr_ptr.
  always_comb begin
    sel_found_s = |pending_r;
    sel_idx_s   = {SW{1'b0}};
    best_dist_s = N_SRC;
    dist_s      = 0;
    for (int k = 0; k < N_SRC; k++) begin
      dist_s = (k + 2 * N_SRC - int'(rr_ptr_r) - 1) % N_SRC;
      if (pending_r[k] && (dist_s < best_dist_s)) begin
        best_dist_s = dist_s;
        sel_idx_s   = SW'(k);
      end else begin
        best_dist_s = best_dist_s;
      end
    end
  end

  // Counters, sticky pending flags and the sticky threshold interrupt.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < N_SRC; k++) begin
        cnt_r[k] <= CNT_ZERO;
      end
      pending_r <= {N_SRC{1'b0}};
      irq_r     <= 1'b0;
    end else if (clear_i) begin
      // Errors coincident with clear are recorded on top of the wiped state.
      for (int k = 0; k < N_SRC; k++) begin
        cnt_r[k] <= error_i[k] ? CNT_ONE : CNT_ZERO;
      end
      pending_r <= error_i;
      irq_r     <= 1'b0;
    end else begin
      for (int k = 0; k < N_SRC; k++) begin
        cnt_r[k] <= cnt_nxt_s[k];
      end
      pending_r <= (pending_r & ~hs_mask_s) | error_i;
      irq_r     <= irq_r | thr_hit_s;
    end
  end

  // Report FSM with registered handshake outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      evt_valid_r <= 1'b0;
      evt_src_r   <= {SW{1'b0}};
      evt_cnt_r   <= CNT_ZERO;
      rr_ptr_r    <= RR_INIT;
    end else if (clear_i) begin
      state_r     <= ST_IDLE;
      evt_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (sel_found_s) begin
            evt_src_r   <= sel_idx_s;
            evt_cnt_r   <= cnt_r[sel_idx_s];
            evt_valid_r <= 1'b1;
            state_r     <= ST_REPORT;
          end else begin
            evt_valid_r <= 1'b0;
          end
        end
        ST_REPORT: begin
          if (hs_s) begin
            evt_valid_r <= 1'b0;
            rr_ptr_r    <= evt_src_r;
            state_r     <= ST_IDLE;
          end else begin
            evt_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          evt_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign evt_valid_o = evt_valid_r;
  assign evt_src_o   = evt_src_r;
  assign evt_cnt_o   = evt_cnt_r;
  assign pending_o   = pending_r;
  assign irq_o       = irq_r;

endmodule
